commit_checker: RTL

COMMIT_CHECKER -- requirements
Module: commit_checker

---
 rtl/riscv_pkg.sv | 50 +++++
 rtl/commit_checker_if.sv | 42 ++++
 rtl/commit_fifo.sv | 52 +++++
 rtl/commit_checker.sv | 110 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V retire-trace types: data width, mismatch codes, the retire
// record layout and the record compare used by the commit checker.
package riscv_pkg;

    localparam int XLEN = 32;

    // Field code of a failed compare, in priority order.
    typedef enum logic [2:0] {
        MM_NONE    = 3'd0,
        MM_PC      = 3'd1,
        MM_INSTR   = 3'd2,
        MM_RD_WE   = 3'd3,
        MM_RD_ADDR = 3'd4,
        MM_RD_DATA = 3'd5
    } mismatch_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            rd_we;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_data;
    } retire_rec_t;

    localparam int REC_W = $bits(retire_rec_t);

    // Compare a retired record against its golden counterpart. A write to x0
    // is architecturally invisible, so it counts as no write on either side,
    // and rd_addr/rd_data only matter when both sides really write.
    function automatic mismatch_t compare_rec(input retire_rec_t act, input retire_rec_t exp);
        mismatch_t res;
        logic      a_we;
        logic      e_we;
        res  = MM_NONE;
        a_we = act.rd_we && (act.rd_addr != 5'd0);
        e_we = exp.rd_we && (exp.rd_addr != 5'd0);
        if (act.pc != exp.pc)
            res = MM_PC;
        else if (act.instr != exp.instr)
            res = MM_INSTR;
        else if (a_we != e_we)
            res = MM_RD_WE;
        else if (a_we && (act.rd_addr != exp.rd_addr))
            res = MM_RD_ADDR;
        else if (a_we && (act.rd_data != exp.rd_data))
            res = MM_RD_DATA;
        return res;
    endfunction

endpackage

// File: rtl/commit_checker_if.sv
// Retire/golden-trace bus of the commit checker. The master is the trace
// source (core retire port plus golden model), the slave is the checker.
interface commit_checker_if;
    import riscv_pkg::*;

    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic [31:0]     retire_instr;
    logic            retire_rd_we;
    logic [4:0]      retire_rd_addr;
    logic [XLEN-1:0] retire_rd_data;

    logic            gold_valid;
    logic            gold_ready;
    logic [XLEN-1:0] gold_pc;
    logic [31:0]     gold_instr;
    logic            gold_rd_we;
    logic [4:0]      gold_rd_addr;
    logic [XLEN-1:0] gold_rd_data;

    logic            mismatch;
    mismatch_t       mismatch_field;
    logic [XLEN-1:0] mismatch_pc;
    logic [31:0]     commit_count;
    logic            overflow;
    logic            halted;

    modport master (
        output retire_valid, retire_pc, retire_instr, retire_rd_we, retire_rd_addr, retire_rd_data,
        output gold_valid, gold_pc, gold_instr, gold_rd_we, gold_rd_addr, gold_rd_data,
        input  gold_ready,
        input  mismatch, mismatch_field, mismatch_pc, commit_count, overflow, halted
    );

    modport slave (
        input  retire_valid, retire_pc, retire_instr, retire_rd_we, retire_rd_addr, retire_rd_data,
        input  gold_valid, gold_pc, gold_instr, gold_rd_we, gold_rd_addr, gold_rd_data,
        output gold_ready,
        output mismatch, mismatch_field, mismatch_pc, commit_count, overflow, halted
    );

endinterface

// File: rtl/commit_fifo.sv
// Retire-record FIFO. A push into a full FIFO succeeds when a pop happens in
// the same cycle; otherwise it is refused and the caller sees full. clear
// empties the FIFO and wins over push/pop.
module commit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear has priority over any transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/commit_checker.sv
// Commit checker: buffers retired instructions, pops them against a golden
// trace, and records the first divergence, commit count and overflow.
module commit_checker
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH       = 4,
    parameter bit STOP_ON_MISMATCH = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    commit_checker_if.slave bus
);
    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} checker_state_t;

    checker_state_t  state, state_nxt;
    retire_rec_t     ret_rec;
    retire_rec_t     gold_rec;
    retire_rec_t     head;
    logic [REC_W-1:0] head_raw;
    logic            full;
    logic            empty;
    logic            push;
    logic            hs;
    logic            gold_ready;
    mismatch_t       cmp;

    logic            mismatch_q;
    mismatch_t       field_q;
    logic [XLEN-1:0] mpc_q;
    logic [31:0]     count_q;
    logic            overflow_q;

    assign ret_rec  = '{pc: bus.retire_pc, instr: bus.retire_instr, rd_we: bus.retire_rd_we,
                        rd_addr: bus.retire_rd_addr, rd_data: bus.retire_rd_data};
    assign gold_rec = '{pc: bus.gold_pc, instr: bus.gold_instr, rd_we: bus.gold_rd_we,
                        rd_addr: bus.gold_rd_addr, rd_data: bus.gold_rd_data};
    assign head     = retire_rec_t'(head_raw);

    // Retire port has no backpressure: records only enter while running.
    assign push       = bus.retire_valid && (state == ST_RUN);
    assign gold_ready = !empty && (state == ST_RUN);
    assign hs         = bus.gold_valid && gold_ready;
    assign cmp        = compare_rec(head, gold_rec);

    commit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REC_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (push),
        .pop   (hs),
        .din   (ret_rec),
        .dout  (head_raw),
        .full  (full),
        .empty (empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state <= ST_RUN;
        else if (clear) state <= ST_RUN;
        else            state <= state_nxt;
    end

    // Next state: a failing compare halts when configured to stop.
    always_comb begin
        state_nxt = state;
        if (state == ST_RUN && hs && cmp != MM_NONE && STOP_ON_MISMATCH)
            state_nxt = ST_HALT;
    end

    // Registered compare results, overflow and commit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
            field_q    <= MM_NONE;
            mpc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            mismatch_q <= 1'b0;
            field_q    <= MM_NONE;
            mpc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push && full && !hs) overflow_q <= 1'b1;
            if (hs) begin
                if (cmp == MM_NONE) begin
                    count_q <= count_q + 32'd1;
                end else begin
                    mismatch_q <= 1'b1;
                    if (!mismatch_q) begin
                        field_q <= cmp;
                        mpc_q   <= head.pc;
                    end
                end
            end
        end
    end

    assign bus.gold_ready     = gold_ready;
    assign bus.mismatch       = mismatch_q;
    assign bus.mismatch_field = field_q;
    assign bus.mismatch_pc    = mpc_q;
    assign bus.commit_count   = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.halted         = (state == ST_HALT);

endmodule
